// File: rtl/cntr8_ctrl.sv
// cntr8_ctrl: command sequencer and shadow-model checker
// for the 8-bit up/down counter cntr8.
module cntr8_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       load,
  output logic       inc,
  output logic [7:0] d_in,
  input  logic [7:0] cnt_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] expected,
  output logic       mismatch,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    S_RST,
    S_HOLD,
    S_LOAD,
    S_UP,
    S_DOWN
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t     state;
  logic [7:0] steps;

  logic       accept;
  logic       op_load;
  logic       op_up;
  logic       op_down;
  logic       n_zero;
  logic       last_step;
  logic [7:0] exp_inc;
  logic [7:0] exp_dec;

  // Decode the handshake and precompute the shadow neighbours.
  always_comb begin
    accept    = cmd_valid && cmd_ready;
    op_load   = cmd_op == OP_LOAD;
    op_up     = cmd_op == OP_UP;
    op_down   = cmd_op == OP_DOWN;
    n_zero    = cmd_data == 8'h00;
    last_step = steps == 8'd1;
    exp_inc   = expected + 8'd1;
    exp_dec   = expected - 8'd1;
  end

  // Sequencer: drives the counter pins and the shadow count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      steps     <= 8'h00;
      expected  <= 8'h00;
      load      <= 1'b0;
      inc       <= 1'b0;
      d_in      <= 8'h00;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_RST: begin
          state     <= S_HOLD;
          load      <= 1'b1;
          inc       <= 1'b0;
          d_in      <= expected;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        S_HOLD: begin
          if (accept) begin
            unique case (1'b1)
              op_load: begin
                state     <= S_LOAD;
                d_in      <= cmd_data;
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              op_up: begin
                if (n_zero) begin
                  done <= 1'b1;
                end else begin
                  state     <= S_UP;
                  load      <= 1'b0;
                  inc       <= 1'b1;
                  steps     <= cmd_data;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                end
              end
              op_down: begin
                if (n_zero) begin
                  done <= 1'b1;
                end else begin
                  state     <= S_DOWN;
                  load      <= 1'b0;
                  inc       <= 1'b0;
                  steps     <= cmd_data;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                end
              end
              // NOP: nothing to drive, just acknowledge.
              default: begin
                done <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          state     <= S_HOLD;
          expected  <= d_in;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        S_UP: begin
          expected <= exp_inc;
          steps    <= steps - 8'd1;
          if (last_step) begin
            state     <= S_HOLD;
            load      <= 1'b1;
            inc       <= 1'b0;
            d_in      <= exp_inc;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DOWN: begin
          expected <= exp_dec;
          steps    <= steps - 8'd1;
          if (last_step) begin
            state     <= S_HOLD;
            load      <= 1'b1;
            inc       <= 1'b0;
            d_in      <= exp_dec;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state <= S_RST;
        end
      endcase
    end
  end

  // Checker: compare counter against shadow outside S_RST;
  // the flag is sticky and the error count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch  <= 1'b0;
      err_count <= 8'h00;
    end else if (state != S_RST && cnt_in != expected) begin
      mismatch <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cntr8_ctrl.sv
// tb_cntr8_ctrl: randomized scoreboard bench for cntr8_ctrl
// with a behavioural cntr8 attached to the counter pins.
module tb_cntr8_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       load;
  logic       inc;
  logic [7:0] d_in;
  logic [7:0] cnt_in;
  logic       busy;
  logic       done;
  logic [7:0] expected;
  logic       mismatch;
  logic [7:0] err_count;

  logic       cnt_rst;
  logic [7:0] cnt_q;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h55;

  typedef struct {
    int         p;
    int         lat;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_cnt[int];
  logic [7:0] ref_count = 8'h00;
  int         n_forced;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         hold_ok = 1'b0;

  cntr8_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .load      (load),
    .inc       (inc),
    .d_in      (d_in),
    .cnt_in    (cnt_in),
    .busy      (busy),
    .done      (done),
    .expected  (expected),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The counter's reset leaves one edge later, so the
  // controller's S_RST cycle does not step it.
  always @(posedge clk or posedge reset)
    if (reset) cnt_rst <= 1'b1;
    else       cnt_rst <= 1'b0;

  // Behavioural cntr8: load, else step up or down.
  always @(posedge clk or posedge cnt_rst)
    if (cnt_rst)   cnt_q <= 8'h00;
    else if (load) cnt_q <= d_in;
    else if (inc)  cnt_q <= cnt_q + 8'd1;
    else           cnt_q <= cnt_q - 8'd1;

  assign cnt_in = force_en ? force_val : cnt_q;

  // Edges at which the counter input disagreed with the model.
  always @(posedge clk or posedge reset)
    if (reset) n_forced <= 0;
    else if (force_en && force_val != ref_count)
      n_forced <= n_forced + 1;

  task automatic chk(input string name, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d",
               name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle flag checks, trace and done scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      chk("mismatch", int'(mismatch), int'(n_forced != 0));
      chk("err_count", int'(err_count),
          (n_forced > 255) ? 255 : n_forced);
      if (exp_cnt.exists(cyc)) begin
        chk("cnt_in trace", int'(cnt_in), int'(exp_cnt[cyc]));
        exp_cnt.delete(cyc);
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected done: no command pending cycle=%0d",
                   cyc);
        end else begin
          e = sb.pop_front();
          chk("done latency", cyc - e.p, e.lat);
          chk("expected at done", int'(expected), int'(e.val));
          chk("cnt_in at done", int'(cnt_in), int'(e.val));
        end
      end
      if (hold_ok && sb.size() == 0) begin
        chk("idle load", int'(load), 1);
        chk("idle busy", int'(busy), 0);
        chk("idle d_in", int'(d_in), int'(ref_count));
        chk("idle expected", int'(expected), int'(ref_count));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    exp_t       e;
    int         t;
    logic [7:0] v;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    t = 0;
    while (!cmd_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      chk("accept timeout", int'(cmd_ready), 1);
      cmd_valid = 1'b0;
      return;
    end
    e.p   = cyc;
    e.val = ref_count;
    e.lat = 1;
    case (op)
      2'b01: begin
        e.lat = 2;
        e.val = data;
        exp_cnt[cyc + 2] = data;
      end
      2'b10, 2'b11: begin
        e.lat = (data == 8'h00) ? 1 : int'(data) + 1;
        for (int k = 1; k <= int'(data); k++) begin
          v = (op == 2'b10) ? ref_count + 8'(k)
                            : ref_count - 8'(k);
          exp_cnt[cyc + 1 + k] = v;
        end
        e.val = (op == 2'b10) ? ref_count + data
                              : ref_count - data;
      end
      default: e.lat = 1;
    endcase
    ref_count = e.val;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain timeout", sb.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst load", int'(load), 0);
    chk("rst inc", int'(inc), 0);
    chk("rst d_in", int'(d_in), 0);
    chk("rst cmd_ready", int'(cmd_ready), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst expected", int'(expected), 0);
    chk("rst mismatch", int'(mismatch), 0);
    chk("rst err_count", int'(err_count), 0);
  endtask

  task automatic apply_reset(input int cycles);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    force_en  = 1'b0;
    hold_ok   = 1'b0;
    sb.delete();
    exp_cnt.delete();
    ref_count = 8'h00;
    #1;
    chk_reset_vals();
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    chk("S_RST cycle cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("first cmd_ready", int'(cmd_ready), 1);
    chk("first hold load", int'(load), 1);
    chk("first hold d_in", int'(d_in), 0);
    hold_ok = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [7:0] data;
    #2;
    apply_reset(3);

    // Idle with the counter attached.
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("idle cnt_in", int'(cnt_in), 0);

    // LOAD 3C then UP 5 accepted in the done cycle.
    send(2'b01, 8'h3C);
    send(2'b10, 8'd5);
    wait_idle();
    chk("up5 expected", int'(expected), 8'h41);

    // Wrap both ways.
    send(2'b01, 8'hFD);
    send(2'b10, 8'd4);
    send(2'b11, 8'd3);
    wait_idle();
    chk("wrap expected", int'(expected), 8'hFE);
    chk("wrap err_count", int'(err_count), 0);

    // Zero-step and NOP.
    send(2'b10, 8'd0);
    send(2'b00, 8'hA7);
    send(2'b11, 8'd0);
    wait_idle();
    chk("nop expected", int'(expected), 8'hFE);

    // Random command stream.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b01 || $urandom_range(0, 7) == 0)
        data = 8'($urandom_range(0, 255));
      else
        data = 8'($urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(op, data);
    end
    wait_idle();

    // Reset in the middle of DOWN 10.
    send(2'b01, 8'h20);
    wait_idle();
    send(2'b11, 8'd10);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("busy before reset", int'(busy), 1);
    apply_reset(2);
    send(2'b01, 8'h10);
    wait_idle();
    chk("post-reset expected", int'(expected), 8'h10);
    chk("post-reset cnt_in", int'(cnt_in), 8'h10);

    // Forced compare errors.
    send(2'b01, 8'h3C);
    wait_idle();
    force_en = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("forced mismatch", int'(mismatch), 1);
    chk("forced err_count 2", int'(err_count), 2);
    repeat (298) begin
      @(posedge clk); #1;
    end
    force_en = 1'b0;
    chk("saturated err_count", int'(err_count), 8'hFF);
    @(posedge clk); #1;
    chk("sticky mismatch", int'(mismatch), 1);
    chk("released cnt_in", int'(cnt_in), 8'h3C);
    repeat (3) begin
      @(posedge clk); #1;
    end

    chk("scoreboard left", sb.size(), 0);
    chk("trace left", exp_cnt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cntr8_ctrl.md
# cntr8_ctrl

Command sequencer and self-checker for the 8-bit up/down counter (`cntr8`). It accepts load/up/down commands over a valid/ready handshake and drives the counter's `load`, `inc` and `d_in` pins cycle by cycle. It keeps a shadow model of the expected count and compares it every cycle against the counter's `d_out`. It sits between a test/host sequencer and `cntr8`, on the side that drives the counter's inputs.

## Interface
Parameters:
- none (widths fixed at 8 bits to match `cntr8`)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command this cycle
- `cmd_op`  in  2  command: 00 NOP, 01 LOAD, 10 UP, 11 DOWN
- `cmd_data`  in  8  LOAD value, or step count N for UP/DOWN
- `load`  out  1  to `cntr8.load`
- `inc`  out  1  to `cntr8.inc` (1 = up, 0 = down)
- `d_in`  out  8  to `cntr8.d_in`
- `cnt_in`  in  8  from `cntr8.d_out`
- `busy`  out  1  command in execution
- `done`  out  1  one-cycle pulse when a command completes
- `expected`  out  8  shadow count
- `mismatch`  out  1  sticky compare-failure flag
- `err_count`  out  8  saturating count of compare failures

## Operation
- The counter never holds on its own: with `load`=0 it steps every cycle. The controller therefore holds by driving `load`=1, `d_in`=`expected`.
- States:
  - S_RST: entered on reset. `load`=0, `inc`=0, `cmd_ready`=0. Always moves to S_HOLD on the next edge.
  - S_HOLD: `load`=1, `d_in`=`expected`, `inc`=0, `cmd_ready`=1, `busy`=0.
  - S_LOAD: `load`=1, `d_in`=captured value, `cmd_ready`=0. Lasts one cycle. `expected` takes the captured value at the end of the cycle. Then S_HOLD.
  - S_UP / S_DOWN: `load`=0, `inc`=1 or 0, `cmd_ready`=0. The captured step counter decrements each cycle. `expected` goes ±1 mod 256 each edge. Returns to S_HOLD after exactly N cycles.
- Accept: `cmd_valid && cmd_ready` at a rising edge latches `cmd_op` and `cmd_data`.
  - NOP, or UP/DOWN with N=0: no pin activity, stay in S_HOLD, `done` pulses next cycle.
- `done` is high for exactly the first S_HOLD cycle after a command completes. A new command may be accepted in that same cycle (back-to-back).
- Arithmetic is 8-bit modulo: FF+1=00, 00−1=FF.
- Checking is active in every state except S_RST. At each rising edge where `cnt_in != expected`:
  - `mismatch` is set; it clears only on reset.
  - `err_count` increments, saturating at FF.
- `busy` = state is S_LOAD, S_UP or S_DOWN.
- Reset asserted mid-command: immediate return to reset values; the in-flight command is discarded and no `done` is issued.

## Timing
- Reset values:
  - `load`=0, `inc`=0, `d_in`=00, `cmd_ready`=0, `busy`=0, `done`=0
  - `expected`=00, `mismatch`=0, `err_count`=00
  - state S_RST
- First `cmd_ready`=1 is the second cycle after reset release (one S_RST cycle).
- Counter pins are registered outputs. They change one cycle after acceptance.
- Latency from accept to `done`:
  - LOAD: 2 cycles
  - UP/DOWN with N≥1: N+1 cycles
  - NOP / N=0: 1 cycle
- `expected` and `cnt_in` update on the same edge. `cnt_in` is sampled registered, with no combinational path to any output.
- `cmd_valid` while `cmd_ready`=0 is ignored. The source must hold the command until it is accepted.

## Test plan
- Reset then idle 5 cycles with the counter attached → `load`=1, `d_in`=00, `cnt_in`=00, `mismatch`=0, `cmd_ready` high from cycle 2.
- LOAD 3C, then UP N=5 back-to-back in the `done` cycle → `cnt_in` reads 3D..41, `done` pulses 2 and 6 cycles after the respective accepts, `expected`=41, `mismatch`=0.
- LOAD FD, UP N=4 → sequence FE, FF, 00, 01. Then DOWN N=3 → 00, FF, FE. Wrap is correct and `err_count`=00.
- UP N=0 and NOP → `done` after 1 cycle, `load` stays 1, no change to `expected`.
- Force `cnt_in` to 55 while `expected`=3C for 2 cycles → `mismatch`=1 (sticky), `err_count`=02. With 300 forced errors, `err_count` saturates at FF.
- Assert `reset` during DOWN N=10 at step 4 → all outputs return to reset values immediately, no `done`, and after release a LOAD 10 completes normally.
